phys_reg_free_list: RTL and testbench

Free list allocator for the physical register file. It hands an unused physical register to rename for each new destination; rename uses it to drive the register file's set-not-ready port. It takes back the previous mapping's physical register at commit. It holds one head-pointer checkpoint so branch mispredict recovery returns all speculatively allocated registers in one cycle.

---
 rtl/phys_reg_free_list.sv | 86 ++++++++
 tb/tb_phys_reg_free_list.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular FIFO of free pregs with a one-entry head checkpoint for mispredict recovery.
// Latency: grant and granted preg are combinational (zero cycle); pointer/entry updates land on the next posedge.
// Backpressure: no grant while empty or recovering (rename stalls); frees while full are dropped and flagged sticky.
// Optional FL_BYPASS_EN: when empty, a same-cycle free is handed straight to the allocating request.
module phys_reg_free_list #(
    parameter int NUM_PREGS = 128,
    parameter int NUM_ARCH  = 32,
    parameter int PREG_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              free_valid,
    input  logic [PREG_W-1:0] free_preg,
    input  logic              ckpt_save,
    input  logic              recover,
    output logic [PREG_W:0]   free_count,
    output logic              empty,
    output logic              full,
    output logic              overflow_err
);

    localparam logic [PREG_W:0] CAPACITY  = (PREG_W+1)'(NUM_PREGS);
    localparam logic [PREG_W:0] INIT_FREE = (PREG_W+1)'(NUM_PREGS - NUM_ARCH);
    localparam logic [PREG_W:0] PTR_ONE   = (PREG_W+1)'(1);

    logic [PREG_W-1:0] entry_q [NUM_PREGS];
    logic [PREG_W:0]   head_q;
    logic [PREG_W:0]   tail_q;
    logic [PREG_W:0]   ckpt_q;
    logic [PREG_W:0]   head_adv;
    logic              pop;
    logic              push;
    logic              bypass;

    // Wrap bit keeps full (difference = NUM_PREGS) distinct from empty (difference = 0).
    assign free_count = tail_q - head_q;
    assign empty      = (free_count == '0);
    assign full       = (free_count == CAPACITY);

`ifdef FL_BYPASS_EN
    assign bypass = empty & alloc_req & free_valid & ~recover;
`else
    assign bypass = 1'b0;
`endif

    assign pop        = alloc_req & ~empty & ~recover;
    assign push       = free_valid & ~full & ~bypass;
    assign alloc_gnt  = pop | bypass;
    assign alloc_preg = bypass ? free_preg : entry_q[head_q[PREG_W-1:0]];
    assign head_adv   = pop ? (head_q + PTR_ONE) : head_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= INIT_FREE;
            ckpt_q       <= '0;
            overflow_err <= 1'b0;
        end else begin
            head_q <= recover ? ckpt_q : head_adv;
            if (push) begin
                tail_q <= tail_q + PTR_ONE;
            end
            // Snapshot is taken after this cycle's grant so the branch's own destination survives recovery.
            if (ckpt_save && !recover) begin
                ckpt_q <= head_adv;
            end
            if (free_valid && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                entry_q[i] <= (i < NUM_PREGS - NUM_ARCH) ? PREG_W'(NUM_ARCH + i) : '0;
            end
        end else if (push) begin
            entry_q[tail_q[PREG_W-1:0]] <= free_preg;
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed scenarios plus randomized traffic against a queue-based model.
module tb_phys_reg_free_list;

    localparam int NP = 128;
    localparam int NA = 32;
    localparam int W  = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         alloc_req;
    logic         alloc_gnt;
    logic [W-1:0] alloc_preg;
    logic         free_valid;
    logic [W-1:0] free_preg;
    logic         ckpt_save;
    logic         recover;
    logic [W:0]   free_count;
    logic         empty;
    logic         full;
    logic         overflow_err;

    int checks = 0;
    int errors = 0;

    // Model: free registers in allocation order, plus registers handed out since the last checkpoint.
    int mq[$];
    int ms[$];
    bit movf;

    phys_reg_free_list #(.NUM_PREGS(NP), .NUM_ARCH(NA), .PREG_W(W)) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_preg(alloc_preg),
        .free_valid(free_valid), .free_preg(free_preg),
        .ckpt_save(ckpt_save), .recover(recover),
        .free_count(free_count), .empty(empty), .full(full), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        ms.delete();
        for (int i = NA; i < NP; i++) mq.push_back(i);
        movf = 1'b0;
    endtask

    task automatic model_step(input bit req, input bit fv, input int fp, input bit sv, input bit rc);
        bit emp, ful, byp, pp;
        emp = (mq.size() == 0);
        ful = (mq.size() == NP);
        byp = 1'b0;
`ifdef FL_BYPASS_EN
        byp = emp && req && fv && !rc;
`endif
        pp = req && !emp && !rc;
        if (fv && ful) movf = 1'b1;
        if (rc) begin
            mq = {ms, mq};
            ms.delete();
        end else if (pp) begin
            ms.push_back(mq.pop_front());
        end
        if (fv && !ful && !byp) mq.push_back(fp);
        if (sv && !rc) ms.delete();
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later, well away from posedge.
    task automatic set_in(input bit req, input bit fv, input int fp, input bit sv, input bit rc);
        @(negedge clk);
        alloc_req  = req;
        free_valid = fv;
        free_preg  = W'(fp);
        ckpt_save  = sv;
        recover    = rc;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        alloc_req = 0; free_valid = 0; free_preg = '0; ckpt_save = 0; recover = 0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        set_in(0, 0, 0, 0, 0);
        checks++; if (free_count !== 8'd96) begin errors++; $display("FAIL reset_count got %0d exp 96", free_count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty got %0b exp 0", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %0b exp 0", alloc_gnt); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow_err); end
        checks++; if (alloc_preg !== 7'd32) begin errors++; $display("FAIL reset_preg got %0d exp 32", alloc_preg); end
    endtask

    task automatic test_alloc_basic();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 0, 0, 0);
            checks++; if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL basic_gnt[%0d] got %0b exp 1", k, alloc_gnt); end
            checks++; if (alloc_preg !== W'(NA + k)) begin errors++; $display("FAIL basic_preg[%0d] got %0d exp %0d", k, alloc_preg, NA + k); end
        end
        set_in(0, 0, 0, 0, 0);
        checks++; if (free_count !== 8'd93) begin errors++; $display("FAIL basic_count got %0d exp 93", free_count); end
    endtask

    task automatic test_drain_empty();
        for (int k = 0; k < 93; k++) begin
            set_in(1, 0, 0, 0, 0);
            checks++; if (alloc_gnt !== 1'b1 || alloc_preg !== W'(35 + k)) begin
                errors++; $display("FAIL drain[%0d] got gnt=%0b preg=%0d exp gnt=1 preg=%0d", k, alloc_gnt, alloc_preg, 35 + k);
            end
        end
        set_in(0, 0, 0, 0, 0);
        checks++; if (empty !== 1'b1 || free_count !== 8'd0) begin errors++; $display("FAIL drain_empty got empty=%0b count=%0d exp 1/0", empty, free_count); end
        set_in(1, 0, 0, 0, 0);
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL empty_block got %0b exp 0", alloc_gnt); end
        set_in(1, 1, 5, 0, 0);
`ifdef FL_BYPASS_EN
        checks++; if (alloc_gnt !== 1'b1 || alloc_preg !== 7'd5) begin errors++; $display("FAIL bypass got gnt=%0b preg=%0d exp 1/5", alloc_gnt, alloc_preg); end
        set_in(0, 0, 0, 0, 0);
        checks++; if (free_count !== 8'd0) begin errors++; $display("FAIL bypass_count got %0d exp 0", free_count); end
`else
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL empty_free_gnt got %0b exp 0", alloc_gnt); end
        set_in(1, 0, 0, 0, 0);
        checks++; if (alloc_gnt !== 1'b1 || alloc_preg !== 7'd5) begin errors++; $display("FAIL refill got gnt=%0b preg=%0d exp 1/5", alloc_gnt, alloc_preg); end
        set_in(0, 0, 0, 0, 0);
        checks++; if (free_count !== 8'd0) begin errors++; $display("FAIL refill_count got %0d exp 0", free_count); end
`endif
    endtask

    task automatic test_checkpoint();
        apply_reset();
        for (int k = 0; k < 8; k++) set_in(1, 0, 0, 0, 0);
        set_in(1, 0, 0, 1, 0);
        checks++; if (alloc_gnt !== 1'b1 || alloc_preg !== 7'd40) begin errors++; $display("FAIL ckpt_alloc got gnt=%0b preg=%0d exp 1/40", alloc_gnt, alloc_preg); end
        set_in(0, 0, 0, 0, 0);
        checks++; if (free_count !== 8'd87) begin errors++; $display("FAIL ckpt_count got %0d exp 87", free_count); end
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 0, 0, 0);
            checks++; if (alloc_preg !== W'(41 + k)) begin errors++; $display("FAIL spec_preg[%0d] got %0d exp %0d", k, alloc_preg, 41 + k); end
        end
        set_in(1, 1, 7, 0, 1);
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL recover_gnt got %0b exp 0", alloc_gnt); end
        set_in(1, 0, 0, 0, 0);
        checks++; if (alloc_gnt !== 1'b1 || alloc_preg !== 7'd41) begin errors++; $display("FAIL recover_preg got gnt=%0b preg=%0d exp 1/41", alloc_gnt, alloc_preg); end
        checks++; if (free_count !== 8'd88) begin errors++; $display("FAIL recover_count got %0d exp 88", free_count); end
        set_in(1, 0, 0, 0, 0);
        set_in(0, 0, 0, 1, 1);
        set_in(1, 0, 0, 0, 0);
        checks++; if (free_count !== 8'd88 || alloc_preg !== 7'd41) begin errors++; $display("FAIL save_in_recover got count=%0d preg=%0d exp 88/41", free_count, alloc_preg); end
        set_in(0, 0, 0, 0, 1);
        set_in(0, 0, 0, 0, 0);
        checks++; if (free_count !== 8'd88) begin errors++; $display("FAIL ckpt_kept got %0d exp 88", free_count); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int k = 0; k < 32; k++) set_in(0, 1, k, 0, 0);
        set_in(0, 0, 0, 0, 0);
        checks++; if (full !== 1'b1 || free_count !== 8'd128) begin errors++; $display("FAIL full got full=%0b count=%0d exp 1/128", full, free_count); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b exp 0", overflow_err); end
        set_in(0, 1, 99, 0, 0);
        set_in(0, 0, 0, 0, 0);
        checks++; if (overflow_err !== 1'b1 || free_count !== 8'd128) begin errors++; $display("FAIL ovf_set got ovf=%0b count=%0d exp 1/128", overflow_err, free_count); end
        set_in(1, 1, 3, 0, 0);
        checks++; if (alloc_gnt !== 1'b1 || alloc_preg !== 7'd32) begin errors++; $display("FAIL full_alloc got gnt=%0b preg=%0d exp 1/32", alloc_gnt, alloc_preg); end
        set_in(0, 0, 0, 0, 0);
        checks++; if (free_count !== 8'd127) begin errors++; $display("FAIL full_pair_count got %0d exp 127", free_count); end
        for (int k = 0; k < 10; k++) set_in(1, 1, k, 0, 0);
        set_in(0, 0, 0, 0, 0);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow_err); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4; k++) set_in(1, 0, 0, (k == 3), 0);
        @(negedge clk);
        alloc_req = 0; free_valid = 0; ckpt_save = 0; recover = 0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (free_count !== 8'd96 || alloc_preg !== 7'd32) begin errors++; $display("FAIL async_state got count=%0d preg=%0d exp 96/32", free_count, alloc_preg); end
        checks++; if (overflow_err !== 1'b0 || empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL async_flags got ovf=%0b empty=%0b full=%0b exp 0/0/0", overflow_err, empty, full); end
        #1;
        reset = 1'b1;
        model_reset();
        set_in(0, 0, 0, 0, 1);
        set_in(1, 0, 0, 0, 0);
        checks++; if (alloc_gnt !== 1'b1 || alloc_preg !== 7'd32 || free_count !== 8'd96) begin
            errors++; $display("FAIL async_first got gnt=%0b preg=%0d count=%0d exp 1/32/96", alloc_gnt, alloc_preg, free_count);
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        int fp;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            fp = $urandom_range(0, NP - 1);
            set_in(1, 1, fp, 0, 0);
            checks++; if (alloc_gnt !== 1'b1 || alloc_preg !== W'(mq[0]) || free_count !== 8'd96) begin
                errors++; $display("FAIL wrap[%0d] got gnt=%0b preg=%0d count=%0d exp 1/%0d/96", n, alloc_gnt, alloc_preg, free_count, mq[0]);
            end
            model_step(1, 1, fp, 0, 0);
        end
    endtask

    task automatic test_random();
        bit req, fv, sv, rc, emp, ful, byp, egnt;
        int fp, epreg;
        apply_reset();
        for (int n = 0; n < 800; n++) begin
            req = ($urandom_range(0, 99) < 60);
            fv  = (mq.size() + ms.size() < NP) && ($urandom_range(0, 99) < 50);
            fp  = $urandom_range(0, NP - 1);
            sv  = ($urandom_range(0, 99) < 15);
            rc  = ($urandom_range(0, 99) < 6);
            set_in(req, fv, fp, sv, rc);
            emp = (mq.size() == 0);
            ful = (mq.size() == NP);
            byp = 1'b0;
`ifdef FL_BYPASS_EN
            byp = emp && req && fv && !rc;
`endif
            egnt  = (req && !emp && !rc) || byp;
            epreg = byp ? fp : (emp ? 0 : mq[0]);
            checks++; if (alloc_gnt !== egnt) begin errors++; $display("FAIL rnd_gnt[%0d] got %0b exp %0b", n, alloc_gnt, egnt); end
            if (egnt) begin
                checks++; if (alloc_preg !== W'(epreg)) begin errors++; $display("FAIL rnd_preg[%0d] got %0d exp %0d", n, alloc_preg, epreg); end
            end
            checks++; if (free_count !== (W+1)'(mq.size()) || empty !== emp || full !== ful) begin
                errors++; $display("FAIL rnd_count[%0d] got %0d/%0b/%0b exp %0d/%0b/%0b", n, free_count, empty, full, mq.size(), emp, ful);
            end
            checks++; if (overflow_err !== movf) begin errors++; $display("FAIL rnd_ovf[%0d] got %0b exp %0b", n, overflow_err, movf); end
            model_step(req, fv, fp, sv, rc);
        end
    endtask

    initial begin
        reset = 1'b1;
        alloc_req = 0; free_valid = 0; free_preg = '0; ckpt_save = 0; recover = 0;
        test_reset();
        test_alloc_basic();
        test_drain_empty();
        test_checkpoint();
        test_overflow();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
